// File: rtl/seven_seg_pkg.sv
// Shared glyph codes, segment patterns and prescaler helper for the
// seven-segment scan driver.
package seven_seg_pkg;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_MINUS  = 7'b111_1110;

  function automatic int unsigned tick_div(input int unsigned clk_hz,
                                           input int unsigned step_hz);
    return clk_hz / step_hz;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational digit-code to active-low segment decoder, {CA..CG} order.
module bcd_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (code_i)
      4'h0:       seg_c = 7'b000_0001;
      4'h1:       seg_c = 7'b100_1111;
      4'h2:       seg_c = 7'b001_0010;
      4'h3:       seg_c = 7'b000_0110;
      4'h4:       seg_c = 7'b100_1100;
      4'h5:       seg_c = 7'b010_0100;
      4'h6:       seg_c = 7'b010_0000;
      4'h7:       seg_c = 7'b000_1111;
      4'h8:       seg_c = 7'b000_0000;
      4'h9:       seg_c = 7'b000_0100;
      CODE_MINUS: seg_c = SEG_MINUS;
      default:    seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered frames,
// leading-zero blanking and an all-anodes-off guard after each digit step.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned STEP_HZ      = 4000,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned LZB_EN       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    lzb_i,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_ack
);

  localparam int unsigned TICK_DIV = tick_div(CLK_HZ, STEP_HZ);
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW       = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  ack_q, ack_d;

  logic                  tick_c, wrap_c;
  logic [NUM_DIGITS-1:0] blank_c;
  logic                  run_c;
  logic [3:0]            lz_code_c;
  logic [3:0]            sel_code_c, dec_code_c;
  logic                  sel_dp_c, sel_blank_c;
  logic [6:0]            dec_seg_c;

  assign tick_c = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign wrap_c = tick_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Blank zeros from the top down until a lit glyph (1-9 or minus) appears.
  always_comb begin
    blank_c   = '0;
    run_c     = (LZB_EN != 0) && lzb_i;
    lz_code_c = 4'h0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      lz_code_c = act_dig_q[4*k +: 4];
      if (run_c && (lz_code_c == 4'h0)) blank_c[k] = 1'b1;
      if ((lz_code_c != 4'h0) && (lz_code_c <= CODE_MINUS)) run_c = 1'b0;
    end
  end

  always_comb begin
    sel_code_c  = CODE_BLANK;
    sel_dp_c    = 1'b0;
    sel_blank_c = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_code_c  = act_dig_q[4*k +: 4];
        sel_dp_c    = act_dp_q[k];
        sel_blank_c = blank_c[k];
      end
    end
    dec_code_c = sel_blank_c ? CODE_BLANK : sel_code_c;
  end

  bcd_to_7seg u_dec (
    .code_i (dec_code_c),
    .seg_c  (dec_seg_c)
  );

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    an_d       = '1;
    seg_d      = dec_seg_c;
    dp_d       = ~sel_dp_c;

    if (tick_c) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Active frame only changes at the frame boundary; a coincident load wins.
    if (wrap_c) begin
      if (load_i) begin
        act_dig_d = digits_i;
        act_dp_d  = dp_i;
        ack_d     = 1'b1;
      end else if (pend_vld_q) begin
        act_dig_d = pend_dig_q;
        act_dp_d  = pend_dp_q;
        ack_d     = 1'b1;
      end
      pend_vld_d = 1'b0;
    end else if (load_i) begin
      pend_dig_d = digits_i;
      pend_dp_d  = dp_i;
      pend_vld_d = 1'b1;
    end

    if (cnt_q >= CNT_W'(GUARD_CYCLES)) begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        an_d[k] = (idx_q != IDX_W'(k));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      act_dig_q  <= {NUM_DIGITS{CODE_BLANK}};
      act_dp_q   <= '0;
      pend_dig_q <= {NUM_DIGITS{CODE_BLANK}};
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      ack_q      <= ack_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign frame_ack = ack_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed and random frames against a
// cycle-count-based reference of the scan, blanking and frame-update rules.
module tb_seven_seg_scan_driver;

  localparam int ND    = 4;
  localparam int TDIV  = 10;
  localparam int GUARD = 2;
  localparam int FRAME = ND * TDIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic        lzb_i;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_ack;

  int total = 0;
  int bad   = 0;
  int acks  = 0;

  // Reference state: edges since reset release plus the two frame buffers.
  int          t;
  logic [15:0] act_m, pend_m;
  logic [3:0]  actdp_m, penddp_m;
  logic        pv_m;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .CLK_HZ       (1000),
    .STEP_HZ      (100),
    .GUARD_CYCLES (GUARD),
    .LZB_EN       (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_i  (digits_i),
    .dp_i      (dp_i),
    .load_i    (load_i),
    .lzb_i     (lzb_i),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_ack (frame_ack)
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] c);
    case (c)
      4'd0:    return 7'b000_0001;
      4'd1:    return 7'b100_1111;
      4'd2:    return 7'b001_0010;
      4'd3:    return 7'b000_0110;
      4'd4:    return 7'b100_1100;
      4'd5:    return 7'b010_0100;
      4'd6:    return 7'b010_0000;
      4'd7:    return 7'b000_1111;
      4'd8:    return 7'b000_0000;
      4'd9:    return 7'b000_0100;
      4'd10:   return 7'b111_1110;
      default: return 7'h7F;
    endcase
  endfunction

  // A zero is hidden when every digit above it is zero or a blank code.
  function automatic bit blank_ref(input int k, input logic [15:0] fr, input logic lz);
    logic [3:0] c;
    if (!lz || k == 0) return 1'b0;
    c = fr[4*k +: 4];
    if (c != 4'd0) return 1'b0;
    for (int j = k + 1; j < ND; j++) begin
      c = fr[4*j +: 4];
      if (c >= 4'd1 && c <= 4'd10) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    act_m    = 16'hFFFF;
    pend_m   = 16'hFFFF;
    actdp_m  = 4'h0;
    penddp_m = 4'h0;
    pv_m     = 1'b0;
  endtask

  // One clock: drive inputs, predict registered outputs, check, advance model.
  task automatic step(input logic ld, input logic [15:0] dg, input logic [3:0] dpv,
                      input logic lz);
    int         c, i;
    logic [3:0] an_e, code;
    logic [6:0] seg_e;
    logic       dp_e, ack_e, wrap;
    load_i   = ld;
    digits_i = dg;
    dp_i     = dpv;
    lzb_i    = lz;
    @(posedge clk);
    c    = t % TDIV;
    i    = (t / TDIV) % ND;
    wrap = (t % FRAME) == FRAME - 1;
    an_e = (c < GUARD) ? 4'hF : ~(4'b0001 << i);
    code = blank_ref(i, act_m, lz) ? 4'hF : act_m[4*i +: 4];
    seg_e = seg_ref(code);
    dp_e  = ~actdp_m[i];
    ack_e = wrap && (ld || pv_m);
    if (wrap) begin
      if (ld) begin
        act_m = dg; actdp_m = dpv;
      end else if (pv_m) begin
        act_m = pend_m; actdp_m = penddp_m;
      end
      pv_m = 1'b0;
    end else if (ld) begin
      pend_m = dg; penddp_m = dpv; pv_m = 1'b1;
    end
    t++;
    #1;
    chk("an", {4'b0, an}, {4'b0, an_e});
    chk("seg", {1'b0, seg}, {1'b0, seg_e});
    chk("dp", {7'b0, dp}, {7'b0, dp_e});
    chk("frame_ack", {7'b0, frame_ack}, {7'b0, ack_e});
    if (frame_ack === 1'b1) acks++;
  endtask

  task automatic idle(input int n, input logic lz);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, 4'h0, lz);
  endtask

  task automatic align(input int phase, input logic lz);
    for (int k = 0; k < FRAME; k++) begin
      if ((t % FRAME) == phase) break;
      step(1'b0, 16'h0, 4'h0, lz);
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic        rlz;
    rst_n    = 1'b0;
    load_i   = 1'b0;
    digits_i = 16'h0;
    dp_i     = 4'h0;
    lzb_i    = 1'b0;
    model_reset();
    #12;
    chk("rst_an", {4'b0, an}, 8'h0F);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'b0, dp}, 8'h01);
    chk("rst_ack", {7'b0, frame_ack}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Blank first frame, then 0x1234 with dp on digit 2.
    idle(FRAME + 7, 1'b0);
    acks = 0;
    step(1'b1, 16'h1234, 4'b0100, 1'b0);
    idle(2 * FRAME, 1'b0);
    chk("ack_count_1234", 8'(acks), 8'd1);

    // Minus and zero blanking, then blanking disabled.
    step(1'b1, 16'h0A05, 4'h0, 1'b1);
    idle(2 * FRAME, 1'b1);
    idle(FRAME, 1'b0);
    step(1'b1, 16'h0000, 4'h0, 1'b1);
    idle(2 * FRAME, 1'b1);

    // Two loads in one frame: last wins, single acknowledge.
    align(5, 1'b0);
    acks = 0;
    step(1'b1, 16'h1111, 4'h1, 1'b0);
    idle(6, 1'b0);
    step(1'b1, 16'h2222, 4'h2, 1'b0);
    idle(FRAME, 1'b0);
    chk("ack_count_two_loads", 8'(acks), 8'd1);

    // Load on the wrap edge applies immediately.
    align(FRAME - 1, 1'b0);
    step(1'b1, 16'h5678, 4'h8, 1'b0);
    chk("ack_at_wrap", {7'b0, frame_ack}, 8'h01);
    idle(FRAME, 1'b0);

    // Random frames with zero-heavy digits.
    rlz = 1'b1;
    for (int n = 0; n < 16 * FRAME; n++) begin
      if ((n % FRAME) == 0) rlz = 1'($urandom_range(0, 1));
      for (int d = 0; d < ND; d++)
        rd[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      step(1'($urandom_range(0, 11) == 0), rd, 4'($urandom), rlz);
    end

    // Reset mid-digit with a pending load discards it.
    align(12, 1'b0);
    step(1'b1, 16'h9876, 4'hF, 1'b0);
    idle(3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_an", {4'b0, an}, 8'h0F);
    chk("midrst_seg", {1'b0, seg}, 8'h7F);
    chk("midrst_dp", {7'b0, dp}, 8'h01);
    chk("midrst_ack", {7'b0, frame_ack}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    acks = 0;
    idle(2 * FRAME, 1'b0);
    chk("ack_after_reset", 8'(acks), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
